// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared types and helpers for the pipelined carry-select adder.
// stage_t is the per-stage payload; fields are sized for the widest legal operand.
package pipelined_carry_select_adder_pkg;

  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W-1:0] psum;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
    logic             sub;
  } stage_t;

  function automatic int unsigned calc_nblk(input int unsigned n, input int unsigned blk);
    return (n + blk - 1) / blk;
  endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_csa_block.sv
// W-bit carry-select slice: two ripple chains (carry-in 0 and 1) and a late carry mux.
module csa_block #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic [W:0]   c0;
  logic [W:0]   c1;

  // Both chains are evaluated before the real carry is known.
  always_comb begin
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      s0[i]   = a_i[i] ^ b_i[i] ^ c0[i];
      c0[i+1] = (a_i[i] & b_i[i]) | (c0[i] & (a_i[i] ^ b_i[i]));
      s1[i]   = a_i[i] ^ b_i[i] ^ c1[i];
      c1[i+1] = (a_i[i] & b_i[i]) | (c1[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign sum_c  = cin_i ? s1 : s0;
  assign cout_c = cin_i ? c1[W] : c0[W];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined add/subtract: one carry-select block per stage, carry and operands skewed
// through the pipe, valid/ready handshake with a single global advance.
module pipelined_carry_select_adder
  import pipelined_carry_select_adder_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned BLK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned NBLK = calc_nblk(N, BLK);
  localparam int unsigned LAST = NBLK - 1;

  logic   adv_c;
  stage_t head_c;
  stage_t tail_d;
  stage_t tail_q;
  logic   ovf_q;

  assign adv_c    = out_ready || !out_valid;
  assign in_ready = adv_c;

  // Stage-0 payload: subtract is a + ~b + 1, so cin is dropped when sub=1.
  always_comb begin
    head_c       = '0;
    head_c.valid = in_valid;
    head_c.carry = sub ? 1'b1 : cin;
    head_c.a_rem = MAX_W'(a);
    head_c.b_rem = MAX_W'(sub ? ~b : b);
    head_c.sub   = sub;
  end

  genvar k;
  generate
    for (k = 0; k < int'(NBLK); k++) begin : g_stage
      localparam int unsigned LO = k * BLK;
      localparam int unsigned W  = (k == int'(LAST)) ? (N - LO) : BLK;

      stage_t       src_c;
      stage_t       stage_d;
      stage_t       stage_q;
      logic [W-1:0] blk_sum_c;
      logic         blk_cout_c;

      if (k == 0) begin : g_head
        assign src_c = head_c;
      end else begin : g_link
        assign src_c = g_stage[k-1].stage_q;
      end

      csa_block #(.W(W)) u_blk (
        .a_i    (src_c.a_rem[LO +: W]),
        .b_i    (src_c.b_rem[LO +: W]),
        .cin_i  (src_c.carry),
        .sum_c  (blk_sum_c),
        .cout_c (blk_cout_c)
      );

      always_comb begin
        stage_d               = src_c;
        stage_d.psum[LO +: W] = blk_sum_c;
        stage_d.carry         = blk_cout_c;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '0;
        end else if (adv_c) begin
          stage_q <= stage_d;
        end
      end
    end
  endgenerate

  assign tail_d = g_stage[LAST].stage_d;
  assign tail_q = g_stage[LAST].stage_q;

  // Overflow needs the full top-block sum, so it is registered beside the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv_c) begin
      ovf_q <= (tail_d.a_rem[N-1] == tail_d.b_rem[N-1]) &&
               (tail_d.psum[N-1] != tail_d.a_rem[N-1]);
    end
  end

  assign out_valid = tail_q.valid;
  assign sum       = tail_q.psum[N-1:0];
  assign cout      = tail_q.carry;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed bench for pipelined_carry_select_adder: 8/4, 1/1 and 13/4 instances.
module tb_pipelined_carry_select_adder;

  logic clk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, sub8, co8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, cin1, sub1, co1, ovf1;
  logic [0:0] a1, b1, s1;
  logic        iv13, ir13, ov13, or13, cin13, sub13, co13, ovf13;
  logic [12:0] a13, b13, s13;

  int tests_run;
  int tests_failed;

  localparam logic [7:0] SA   [4] = '{8'h7F, 8'h80, 8'h12, 8'h05};
  localparam logic [7:0] SB   [4] = '{8'h01, 8'h01, 8'h34, 8'h09};
  localparam logic       SCI  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic       SSU  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [7:0] SS   [4] = '{8'h80, 8'h7F, 8'h47, 8'hFC};
  localparam logic       SC   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic       SO   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  localparam logic [7:0] PA   [4] = '{8'h10, 8'hF0, 8'h55, 8'h01};
  localparam logic [7:0] PB   [4] = '{8'h20, 8'h20, 8'h0A, 8'h01};
  localparam logic       PCI  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic       PSU  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [7:0] PS   [4] = '{8'h30, 8'h10, 8'h4B, 8'h03};
  localparam logic       PC   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  pipelined_carry_select_adder #(.N(8), .BLK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(ovf8));

  pipelined_carry_select_adder #(.N(1), .BLK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .ovf(ovf1));

  pipelined_carry_select_adder #(.N(13), .BLK(4)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
    .cin(cin13), .sub(sub13), .out_valid(ov13), .out_ready(or13), .sum(s13),
    .cout(co13), .ovf(ovf13));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference for the 13-bit instance: {cout, ovf, sum}.
  function automatic logic [14:0] ref13(input logic [12:0] a, input logic [12:0] b,
                                         input logic c, input logic s);
    logic [12:0] be;
    logic [13:0] t;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + 14'(s ? 1'b1 : c);
    return {t[13], (a[12] == be[12]) && (t[12] != a[12]), t[12:0]};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({ov8, ir8, s8, co8, ovf8} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset8: got ov=%b ir=%b sum=%h co=%b ovf=%b, expected 0 1 00 0 0",
               ov8, ir8, s8, co8, ovf8);
    end
    tests_run++;
    if ({ov1, ir1, ov13, ir13} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL reset_other: got ov1=%b ir1=%b ov13=%b ir13=%b, expected 0 1 0 1",
               ov1, ir1, ov13, ir13);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    tests_run++;
    if (ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_early: out_valid got %b expected 0 one cycle after input", ov8);
    end
    @(negedge clk);
    tests_run++;
    if ({ov8, s8, co8, ovf8} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_ff01: got ov=%b sum=%h co=%b ovf=%b, expected 1 00 1 0",
               ov8, s8, co8, ovf8);
    end
    @(negedge clk);
    tests_run++;
    if (ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_dup: out_valid got %b expected 0", ov8);
    end
  endtask

  task automatic test_stream;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        tests_run++;
        if ({ov8, s8, co8, ovf8} !== {1'b1, SS[c-2], SC[c-2], SO[c-2]}) begin
          tests_failed++;
          $display("FAIL stream%0d: got ov=%b sum=%h co=%b ovf=%b, expected 1 %h %b %b",
                   c - 2, ov8, s8, co8, ovf8, SS[c-2], SC[c-2], SO[c-2]);
        end
      end else if (c == 6) begin
        tests_run++;
        if (ov8 !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_end: out_valid got %b expected 0", ov8);
        end
      end
      if (c < 4) begin
        a8 = SA[c]; b8 = SB[c]; cin8 = SCI[c]; sub8 = SSU[c]; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    int   in_idx;
    int   out_idx;
    logic exp_ir;
    logic exp_ov;
    in_idx  = 0;
    out_idx = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      or8    = !(c >= 3 && c <= 5);
      exp_ir = !(c >= 3 && c <= 5);
      exp_ov = (c >= 3 && c <= 9);
      if (in_idx < 4) begin
        a8 = PA[in_idx]; b8 = PB[in_idx]; cin8 = PCI[in_idx]; sub8 = PSU[in_idx];
        iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      #1;
      tests_run++;
      if (ir8 !== exp_ir) begin
        tests_failed++;
        $display("FAIL bp_ready c%0d: in_ready got %b expected %b", c, ir8, exp_ir);
      end
      tests_run++;
      if (ov8 !== exp_ov) begin
        tests_failed++;
        $display("FAIL bp_valid c%0d: out_valid got %b expected %b", c, ov8, exp_ov);
      end
      if (exp_ov && out_idx < 4) begin
        tests_run++;
        if ({s8, co8, ovf8} !== {PS[out_idx], PC[out_idx], 1'b0}) begin
          tests_failed++;
          $display("FAIL bp_data c%0d: got sum=%h co=%b ovf=%b expected %h %b 0",
                   c, s8, co8, ovf8, PS[out_idx], PC[out_idx]);
        end
        if (or8) out_idx++;
      end
      if (iv8 && exp_ir) in_idx++;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    a8 = 8'h22; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    a8 = 8'h44;
    @(negedge clk);
    iv8 = 1'b0;
    tests_run++;
    if ({ov8, s8} !== {1'b1, 8'h33}) begin
      tests_failed++;
      $display("FAIL arst_pre: got ov=%b sum=%h expected 1 33", ov8, s8);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ov8, ir8, s8, co8, ovf8} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL arst_now: got ov=%b ir=%b sum=%h co=%b ovf=%b expected 0 1 00 0 0",
               ov8, ir8, s8, co8, ovf8);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (ov8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL arst_stale c%0d: out_valid got %b expected 0", c, ov8);
      end
    end
    a8 = 8'h0F; b8 = 8'h01; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({ov8, s8, co8, ovf8} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL arst_first: got ov=%b sum=%h co=%b ovf=%b expected 1 10 0 0",
               ov8, s8, co8, ovf8);
    end
  endtask

  task automatic test_n1;
    logic [2:0] prev;
    logic [1:0] exp;
    prev = '0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = 2'(prev[2]) + 2'(prev[1]) + 2'(prev[0]);
        tests_run++;
        if ({ov1, co1, s1} !== {1'b1, exp}) begin
          tests_failed++;
          $display("FAIL n1 abc=%b: got ov=%b {co,sum}=%b%b expected 1 %b",
                   prev, ov1, co1, s1, exp);
        end
      end
      if (i < 8) begin
        prev = 3'(i);
        a1 = prev[2]; b1 = prev[1]; cin1 = prev[0]; sub1 = 1'b0; iv1 = 1'b1;
      end else begin
        iv1 = 1'b0;
      end
    end
    @(negedge clk);
    tests_run++;
    if (ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL n1_end: out_valid got %b expected 0", ov1);
    end
  endtask

  task automatic test_n13;
    logic [14:0] exp_q [$];
    int          stamp_q [$];
    logic [14:0] exp;
    int          stamp;
    int          cyc;
    logic        hold;
    logic        acc;
    logic        phase_a;
    cyc  = 0;
    hold = 1'b0;
    for (int c = 0; c < 190; c++) begin
      @(negedge clk);
      cyc++;
      phase_a = (c < 60);
      if (c >= 140) begin
        iv13 = 1'b0;
        or13 = 1'b1;
        if (exp_q.size() == 0) break;
      end else begin
        if (!hold) begin
          iv13  = ($urandom_range(0, 3) != 0);
          a13   = 13'($urandom);
          b13   = 13'($urandom);
          cin13 = 1'($urandom);
          sub13 = 1'($urandom);
        end
        or13 = phase_a ? 1'b1 : ($urandom_range(0, 9) < 7);
      end
      #1;
      if (ov13 && or13) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL n13_extra c%0d: unexpected result sum=%h", cyc, s13);
        end else begin
          exp   = exp_q.pop_front();
          stamp = stamp_q.pop_front();
          if ({co13, ovf13, s13} !== exp) begin
            tests_failed++;
            $display("FAIL n13_data c%0d: got {co,ovf,sum}=%h expected %h",
                     cyc, {co13, ovf13, s13}, exp);
          end
          if (phase_a) begin
            tests_run++;
            if (cyc - stamp != 4) begin
              tests_failed++;
              $display("FAIL n13_latency c%0d: got %0d cycles expected 4", cyc, cyc - stamp);
            end
          end
        end
      end
      acc = iv13 && (or13 || !ov13);
      if (acc) begin
        exp_q.push_back(ref13(a13, b13, cin13, sub13));
        stamp_q.push_back(cyc);
      end
      hold = iv13 && !acc;
    end
    iv13 = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL n13_drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    iv8  = 1'b0; or8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
    iv1  = 1'b0; or1  = 1'b1; a1  = '0; b1  = '0; cin1  = 1'b0; sub1  = 1'b0;
    iv13 = 1'b0; or13 = 1'b1; a13 = '0; b13 = '0; cin13 = 1'b0; sub13 = 1'b0;
    test_reset();
    test_add_basic();
    test_stream();
    test_backpressure();
    test_async_reset();
    test_n1();
    test_n13();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_select_adder.md
PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits, legal range 1..64.
REQ-002 SHALL have parameter BLK, default 4, carry-select block width, legal range 1..N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have port a, input, N bits: operand A.
REQ-008 SHALL have port b, input, N bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 SHALL have port sub, input, 1 bit: 0 = add (a+b+cin), 1 = subtract (a-b).
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port sum, output, N bits: result.
REQ-014 SHALL have port cout, output, 1 bit: carry out of bit N-1; in subtract mode 1 = no borrow.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL define NBLK = ceil(N/BLK) pipeline stages; stage k computes block k (bits k*BLK upward); the top block is narrower when BLK does not divide N.
REQ-017 Each stage SHALL precompute block sums for carry 0 and carry 1 and select between them with the registered carry from stage k-1; stage 0 uses the effective carry-in.
REQ-018 Effective operands SHALL be b_eff = sub ? ~b : b and c_eff = sub ? 1 : cin; cin SHALL be ignored when sub=1.
REQ-019 Unconsumed upper operand blocks and completed lower sum blocks SHALL travel through the pipeline skewed with the carry.
REQ-020 A transfer SHALL occur when in_valid && in_ready (input side) and when out_valid && out_ready (output side).
REQ-021 Global advance SHALL be adv = out_ready || !out_valid; in_ready SHALL equal adv; all stages hold when adv=0.
REQ-022 Latency SHALL be exactly NBLK cycles from input transfer to out_valid while out_ready is held high; throughput SHALL be one result per cycle.
REQ-023 Bubbles (in_valid=0 while adv=1) SHALL propagate as per-stage valid=0 and are not compressed.
REQ-024 While out_valid=1 && out_ready=0, sum, cout and ovf SHALL remain stable.
REQ-025 ovf SHALL equal (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]).
REQ-026 Results SHALL leave the pipeline in acceptance order, with no loss or duplication.
REQ-027 With N=1, BLK=1 the block SHALL behave as a 1-stage registered full adder, latency 1.

Reset
REQ-028 On rst_n=0, all stage valid bits, out_valid, sum, cout and ovf SHALL clear to 0 immediately, without waiting for clk.
REQ-029 in_ready SHALL be 1 during and after reset, since out_valid=0.
REQ-030 Reset mid-operation SHALL discard all in-flight results; the first valid result after release SHALL come from the first input accepted after release.
REQ-031 Datapath registers other than those outputs need no reset; their values are don't-care while invalid.

Structure
REQ-032 A shared package SHALL hold the NBLK computation function and the stage-payload struct typedef (valid, carry, partial sum, remaining a, remaining b_eff, sub flag).
REQ-033 One sub-module, csa_block (parameter W), SHALL implement a W-bit dual-ripple adder plus carry mux; it is instantiated once per stage.
REQ-034 Top-level code SHALL use generate loops over NBLK and contain no per-width special cases beyond the top-block width.

Verification (N=8, BLK=4, latency 2 unless stated)
REQ-035 Add a=8'hFF, b=8'h01, cin=0, sub=0 -> two cycles later sum=8'h00, cout=1, ovf=0.
REQ-036 Add a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; subtract a=8'h80, b=8'h01, sub=1, cin=1 (ignored) -> sum=8'h7F, cout=1, ovf=1.
REQ-037 Stream 4 back-to-back inputs with out_ready=0 on cycles 3-5 -> in_ready=0 on those cycles, outputs held stable, all 4 results delivered in order with no loss.
REQ-038 Assert rst_n=0 asynchronously with 2 results in flight -> out_valid=0 at once, and no stale result appears after release.
REQ-039 N=1, BLK=1 exhaustive over all 8 {a,b,cin} values -> {cout,sum} = a+b+cin one cycle after each input.
REQ-040 N=13, BLK=4 (NBLK=4, top block 1 bit), random add/sub with constrained valid/ready -> every result matches the reference model, latency 4.
